op_dispatch: RTL and testbench

OP_DISPATCH -- requirements
Module: op_dispatch

---
 rtl/fpu_pkg.sv | 44 ++++
 rtl/op_dispatch_tag_fifo.sv | 76 +++++++
 rtl/op_dispatch.sv | 200 ++++++++++++++++++++
 tb/tb_op_dispatch.sv | 237 +++++++++++++++++++++++
 4 files changed

// File: rtl/fpu_pkg.sv
// Shared FPU dispatch definitions.
// Holds the 3-bit op tag type used by the dispatcher and the output stage.
// Also holds the opcode constants, the dispatcher FSM state enum and small
// decode helpers.
package fpu_pkg;

    typedef logic [2:0] op_t;

    localparam op_t OP_NOP = 3'b000;
    localparam op_t OP_ADD = 3'b001;
    localparam op_t OP_SUB = 3'b010;
    localparam op_t OP_MUL = 3'b011;
    localparam op_t OP_SIN = 3'b100;

    typedef enum logic {
        ST_IDLE  = 1'b0,
        ST_ISSUE = 1'b1
    } state_t;

    // Execution unit targeted by an opcode; UNIT_NONE covers NOP and illegal codes.
    typedef enum logic [1:0] {
        UNIT_NONE = 2'd0,
        UNIT_ADD  = 2'd1,
        UNIT_MUL  = 2'd2,
        UNIT_SIN  = 2'd3
    } unit_t;

    function automatic unit_t op_unit(input op_t op);
        unit_t u;
        case (op)
            OP_ADD, OP_SUB: u = UNIT_ADD;
            OP_MUL:         u = UNIT_MUL;
            OP_SIN:         u = UNIT_SIN;
            default:        u = UNIT_NONE;
        endcase
        return u;
    endfunction

    // Sign flip turns the adder into a subtractor: a - b == a + (-b).
    function automatic logic [31:0] f32_negate(input logic [31:0] x);
        return {~x[31], x[30:0]};
    endfunction

endpackage

// File: rtl/op_dispatch_tag_fifo.sv
// tag_fifo: in-order FIFO of outstanding op tags.
// Ports: clk, rst (async, active high), push/data write side, pop read side,
//        head (oldest tag, 000 when empty), full, empty, count.
// Push is refused when full and pop is refused when empty, whatever the other
// side does in the same cycle.
module tag_fifo
    import fpu_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     push,
    input  logic                     pop,
    input  op_t                      data,
    output op_t                      head,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;
    localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);
    localparam logic [CW-1:0] ONE_C   = CW'(1);
    localparam logic [AW-1:0] STEP_C  = AW'(1);

    op_t           mem_r [DEPTH];
    logic [AW-1:0] wr_ptr_r;
    logic [AW-1:0] rd_ptr_r;
    logic [CW-1:0] count_r;
    logic          push_ok_s;
    logic          pop_ok_s;

    assign full      = (count_r == DEPTH_C);
    assign empty     = (count_r == {CW{1'b0}});
    assign count     = count_r;
    assign push_ok_s = push & ~full;
    assign pop_ok_s  = pop & ~empty;

    // Storage, pointers and occupancy; power-of-two depth makes pointer wrap free.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_r[i] <= OP_NOP;
            end
            wr_ptr_r <= {AW{1'b0}};
            rd_ptr_r <= {AW{1'b0}};
            count_r  <= {CW{1'b0}};
        end else begin
            if (push_ok_s) begin
                mem_r[wr_ptr_r] <= data;
                wr_ptr_r        <= wr_ptr_r + STEP_C;
            end
            if (pop_ok_s) begin
                rd_ptr_r <= rd_ptr_r + STEP_C;
            end
            case ({push_ok_s, pop_ok_s})
                2'b10:   count_r <= count_r + ONE_C;
                2'b01:   count_r <= count_r - ONE_C;
                default: count_r <= count_r;
            endcase
        end
    end

    // Head tag, forced to NOP when nothing is outstanding.
    always_comb begin
        head = OP_NOP;
        if (empty) begin
            head = OP_NOP;
        end else begin
            head = mem_r[rd_ptr_r];
        end
    end

endmodule

// File: rtl/op_dispatch.sv
// op_dispatch: accepts one FP operation at a time and launches it on the
// add, mul or sine unit once that unit is idle and the tag FIFO has room.
// It records the op tag in order so the output stage can pick results.
// Ports: clk, rst (async, active high); in_valid/in_ready/in_op/in_a/in_b
//        request side; *_start pulses and registered operands per unit;
//        *_done unit completions; result_done pops the head tag; fifo_out and
//        fifo_empty expose the tag FIFO; illegal_op and underflow_err flag
//        errors.
module op_dispatch
    import fpu_pkg::*;
#(
    parameter int FIFO_DEPTH = 4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        in_valid,
    input  logic [2:0]  in_op,
    input  logic [31:0] in_a,
    input  logic [31:0] in_b,
    output logic        in_ready,
    output logic        add_start,
    output logic        mul_start,
    output logic        sine_start,
    output logic [31:0] add_a,
    output logic [31:0] add_b,
    output logic [31:0] mul_a,
    output logic [31:0] mul_b,
    output logic [31:0] sine_x,
    input  logic        add_done,
    input  logic        mul_done,
    input  logic        sine_done,
    input  logic        result_done,
    output logic [2:0]  fifo_out,
    output logic        fifo_empty,
    output logic        illegal_op,
    output logic        underflow_err
);

    localparam int CW = $clog2(FIFO_DEPTH) + 1;
    localparam logic [CW-1:0] DEPTH_C = CW'(FIFO_DEPTH);

    state_t        state_r, state_nxt_s;
    op_t           hold_op_r;
    logic [31:0]   hold_a_r, hold_b_r;
    logic          add_busy_r, mul_busy_r, sine_busy_r;
    logic [31:0]   add_a_r, add_b_r, mul_a_r, mul_b_r, sine_x_r;
    logic          illegal_op_r, underflow_err_r;

    logic          handshake_s;
    logic          target_busy_s;
    logic          issue_s;
    logic          add_issue_s, mul_issue_s, sine_issue_s;
    unit_t         hold_unit_s;
    logic          fifo_full_s, fifo_empty_s, fifo_pop_s, fifo_push_s;
    logic          fifo_room_s;
    op_t           fifo_head_s;
    logic [CW-1:0] fifo_count_s;

    assign in_ready    = (state_r == ST_IDLE);
    assign handshake_s = in_valid & in_ready;
    assign hold_unit_s = op_unit(hold_op_r);
    assign fifo_room_s = (fifo_count_s < DEPTH_C);
    assign fifo_push_s = issue_s & ~fifo_full_s;
    assign fifo_pop_s  = result_done & ~fifo_empty_s;

    // Next state and issue decision; busy flags are registered so a done pulse
    // only frees its unit from the following cycle.
    always_comb begin
        state_nxt_s   = state_r;
        target_busy_s = 1'b1;
        issue_s       = 1'b0;
        add_issue_s   = 1'b0;
        mul_issue_s   = 1'b0;
        sine_issue_s  = 1'b0;
        case (state_r)
            ST_IDLE: begin
                if (handshake_s && (op_unit(in_op) != UNIT_NONE)) begin
                    state_nxt_s = ST_ISSUE;
                end else begin
                    state_nxt_s = ST_IDLE;
                end
            end
            ST_ISSUE: begin
                case (hold_unit_s)
                    UNIT_ADD: target_busy_s = add_busy_r;
                    UNIT_MUL: target_busy_s = mul_busy_r;
                    UNIT_SIN: target_busy_s = sine_busy_r;
                    default:  target_busy_s = 1'b1;
                endcase
                if (!target_busy_s && fifo_room_s) begin
                    issue_s      = 1'b1;
                    add_issue_s  = (hold_unit_s == UNIT_ADD);
                    mul_issue_s  = (hold_unit_s == UNIT_MUL);
                    sine_issue_s = (hold_unit_s == UNIT_SIN);
                    state_nxt_s  = ST_IDLE;
                end else begin
                    state_nxt_s  = ST_ISSUE;
                end
            end
            default: state_nxt_s = ST_IDLE;
        endcase
    end

    // FSM state; reset drops any request waiting in ISSUE.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= state_nxt_s;
        end
    end

    // Request holding register, loaded on every accepted handshake.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            hold_op_r <= OP_NOP;
            hold_a_r  <= 32'h0000_0000;
            hold_b_r  <= 32'h0000_0000;
        end else if (handshake_s) begin
            hold_op_r <= in_op;
            hold_a_r  <= in_a;
            hold_b_r  <= in_b;
        end
    end

    // Unit busy flags: issue sets, done clears, set wins on a tie.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            add_busy_r  <= 1'b0;
            mul_busy_r  <= 1'b0;
            sine_busy_r <= 1'b0;
        end else begin
            add_busy_r  <= add_issue_s  | (add_busy_r  & ~add_done);
            mul_busy_r  <= mul_issue_s  | (mul_busy_r  & ~mul_done);
            sine_busy_r <= sine_issue_s | (sine_busy_r & ~sine_done);
        end
    end

    // Unit operand registers; each holds until the next issue to its unit.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            add_a_r  <= 32'h0000_0000;
            add_b_r  <= 32'h0000_0000;
            mul_a_r  <= 32'h0000_0000;
            mul_b_r  <= 32'h0000_0000;
            sine_x_r <= 32'h0000_0000;
        end else begin
            if (add_issue_s) begin
                add_a_r <= hold_a_r;
                add_b_r <= (hold_op_r == OP_SUB) ? f32_negate(hold_b_r) : hold_b_r;
            end
            if (mul_issue_s) begin
                mul_a_r <= hold_a_r;
                mul_b_r <= hold_b_r;
            end
            if (sine_issue_s) begin
                sine_x_r <= hold_a_r;
            end
        end
    end

    // Error pulses, one cycle after the offending event.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            illegal_op_r    <= 1'b0;
            underflow_err_r <= 1'b0;
        end else begin
            illegal_op_r    <= handshake_s & (op_unit(in_op) == UNIT_NONE) & (in_op != OP_NOP);
            underflow_err_r <= result_done & fifo_empty_s;
        end
    end

    tag_fifo #(
        .DEPTH (FIFO_DEPTH)
    ) u_tag_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (fifo_push_s),
        .pop   (fifo_pop_s),
        .data  (hold_op_r),
        .head  (fifo_head_s),
        .full  (fifo_full_s),
        .empty (fifo_empty_s),
        .count (fifo_count_s)
    );

    assign add_start     = add_issue_s;
    assign mul_start     = mul_issue_s;
    assign sine_start    = sine_issue_s;
    assign add_a         = add_a_r;
    assign add_b         = add_b_r;
    assign mul_a         = mul_a_r;
    assign mul_b         = mul_b_r;
    assign sine_x        = sine_x_r;
    assign fifo_out      = fifo_head_s;
    assign fifo_empty    = fifo_empty_s;
    assign illegal_op    = illegal_op_r;
    assign underflow_err = underflow_err_r;

endmodule

// File: tb/tb_op_dispatch.sv
// Self-checking bench for op_dispatch: a table of single-op vectors plus
// hand-written sequences for back-pressure, FIFO-full, underflow and reset.
module tb_op_dispatch;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        in_valid = 1'b0;
    logic [2:0]  in_op = 3'b000;
    logic [31:0] in_a = 32'h0000_0000;
    logic [31:0] in_b = 32'h0000_0000;
    logic        in_ready;
    logic        add_start, mul_start, sine_start;
    logic [31:0] add_a, add_b, mul_a, mul_b, sine_x;
    logic        add_done = 1'b0, mul_done = 1'b0, sine_done = 1'b0;
    logic        result_done = 1'b0;
    logic [2:0]  fifo_out;
    logic        fifo_empty;
    logic        illegal_op;
    logic        underflow_err;

    int n_cmp  = 0;
    int n_fail = 0;

    op_dispatch #(.FIFO_DEPTH(4)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_op(in_op),
        .in_a(in_a), .in_b(in_b), .in_ready(in_ready),
        .add_start(add_start), .mul_start(mul_start), .sine_start(sine_start),
        .add_a(add_a), .add_b(add_b), .mul_a(mul_a), .mul_b(mul_b), .sine_x(sine_x),
        .add_done(add_done), .mul_done(mul_done), .sine_done(sine_done),
        .result_done(result_done), .fifo_out(fifo_out), .fifo_empty(fifo_empty),
        .illegal_op(illegal_op), .underflow_err(underflow_err)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [2:0]  op;
        logic [31:0] a;
        logic [31:0] b;
        logic [2:0]  start;   // {sine, mul, add} expected one cycle after handshake
        logic        rdy1;    // in_ready expected one cycle after handshake
        logic        ill;     // illegal_op expected one cycle after handshake
        logic [31:0] p;       // first operand output of the target unit
        logic [31:0] q;       // second operand output (add/mul only)
        logic [2:0]  tag;     // fifo_out two cycles after handshake
    } vec_t;

    vec_t vecs [8];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Present one request for a single cycle; returns in the cycle after the handshake.
    task automatic do_req(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
        in_valid = 1'b1;
        in_op    = op;
        in_a     = a;
        in_b     = b;
        step();
        in_valid = 1'b0;
    endtask

    function automatic logic [31:0] starts();
        return {29'd0, sine_start, mul_start, add_start};
    endfunction

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic [2:0] drain_tags [4];
        logic       seen;

        //               op      a             b             start   rdy1  ill   p             q             tag
        vecs[0] = '{3'b001, 32'h3F800000, 32'h40000000, 3'b001, 1'b0, 1'b0, 32'h3F800000, 32'h40000000, 3'b001};
        vecs[1] = '{3'b010, 32'h3F800000, 32'h40000000, 3'b001, 1'b0, 1'b0, 32'h3F800000, 32'hC0000000, 3'b010};
        vecs[2] = '{3'b011, 32'h40400000, 32'hC0800000, 3'b010, 1'b0, 1'b0, 32'h40400000, 32'hC0800000, 3'b011};
        vecs[3] = '{3'b100, 32'h3FC90FDB, 32'hDEADBEEF, 3'b100, 1'b0, 1'b0, 32'h3FC90FDB, 32'h00000000, 3'b100};
        vecs[4] = '{3'b110, 32'h11111111, 32'h22222222, 3'b000, 1'b1, 1'b1, 32'h00000000, 32'h00000000, 3'b000};
        vecs[5] = '{3'b111, 32'h33333333, 32'h44444444, 3'b000, 1'b1, 1'b1, 32'h00000000, 32'h00000000, 3'b000};
        vecs[6] = '{3'b000, 32'h55555555, 32'h66666666, 3'b000, 1'b1, 1'b0, 32'h00000000, 32'h00000000, 3'b000};
        vecs[7] = '{3'b010, 32'h40A00000, 32'hC0000000, 3'b001, 1'b0, 1'b0, 32'h40A00000, 32'h40000000, 3'b010};

        // ---- reset state ----
        step();
        step();
        rst = 1'b0;
        step();
        chk("rst_in_ready",   32'(in_ready), 32'd1);
        chk("rst_fifo_empty", 32'(fifo_empty), 32'd1);
        chk("rst_fifo_out",   32'(fifo_out), 32'd0);
        chk("rst_starts",     starts(), 32'd0);
        chk("rst_errors",     {30'd0, illegal_op, underflow_err}, 32'd0);
        chk("rst_add_a",      add_a, 32'd0);
        chk("rst_mul_b",      mul_b, 32'd0);
        chk("rst_sine_x",     sine_x, 32'd0);

        // ---- table-driven single operations ----
        for (int i = 0; i < 8; i++) begin
            do_req(vecs[i].op, vecs[i].a, vecs[i].b);
            chk($sformatf("v%0d_start", i),    starts(), 32'(vecs[i].start));
            chk($sformatf("v%0d_in_ready", i), 32'(in_ready), 32'(vecs[i].rdy1));
            chk($sformatf("v%0d_illegal", i),  32'(illegal_op), 32'(vecs[i].ill));
            step();
            chk($sformatf("v%0d_start_off", i), starts(), 32'd0);
            chk($sformatf("v%0d_ready2", i),    32'(in_ready), 32'd1);
            chk($sformatf("v%0d_ill_off", i),   32'(illegal_op), 32'd0);
            chk($sformatf("v%0d_fifo_out", i),  32'(fifo_out), 32'(vecs[i].tag));
            chk($sformatf("v%0d_empty", i),     32'(fifo_empty), 32'(vecs[i].tag == 3'b000));
            if (vecs[i].start[0]) begin
                chk($sformatf("v%0d_add_a", i), add_a, vecs[i].p);
                chk($sformatf("v%0d_add_b", i), add_b, vecs[i].q);
            end
            if (vecs[i].start[1]) begin
                chk($sformatf("v%0d_mul_a", i), mul_a, vecs[i].p);
                chk($sformatf("v%0d_mul_b", i), mul_b, vecs[i].q);
            end
            if (vecs[i].start[2]) begin
                chk($sformatf("v%0d_sine_x", i), sine_x, vecs[i].p);
            end
            if (vecs[i].tag != 3'b000) begin
                result_done = 1'b1;
                add_done = 1'b1; mul_done = 1'b1; sine_done = 1'b1;
                step();
                result_done = 1'b0;
                add_done = 1'b0; mul_done = 1'b0; sine_done = 1'b0;
                chk($sformatf("v%0d_drained", i), 32'(fifo_empty), 32'd1);
            end
        end

        // ---- underflow: result_done with nothing outstanding ----
        result_done = 1'b1;
        step();
        result_done = 1'b0;
        chk("uf_pulse", 32'(underflow_err), 32'd1);
        chk("uf_empty", 32'(fifo_empty), 32'd1);
        step();
        chk("uf_pulse_off", 32'(underflow_err), 32'd0);
        chk("uf_empty2",    32'(fifo_empty), 32'd1);

        // ---- four MULs without result_done: busy back-pressure, then FIFO full ----
        do_req(3'b011, 32'h3F800000, 32'h3F800000);
        chk("m1_start", 32'(mul_start), 32'd1);
        step();
        for (int k = 2; k <= 4; k++) begin
            do_req(3'b011, 32'(k), 32'(k + 16));
            chk($sformatf("m%0d_held", k), 32'(mul_start), 32'd0);
            step();
            chk($sformatf("m%0d_held2", k), {31'd0, mul_start | in_ready}, 32'd0);
            mul_done = 1'b1;
            chk($sformatf("m%0d_done_cycle", k), 32'(mul_start), 32'd0);
            step();
            mul_done = 1'b0;
            chk($sformatf("m%0d_start", k), 32'(mul_start), 32'd1);
            step();
            chk($sformatf("m%0d_mul_a", k), mul_a, 32'(k));
            chk($sformatf("m%0d_mul_b", k), mul_b, 32'(k + 16));
        end
        mul_done = 1'b1;
        step();
        mul_done = 1'b0;
        do_req(3'b001, 32'hAAAA0000, 32'hBBBB0000);
        chk("full_held",  32'(add_start), 32'd0);
        step();
        chk("full_held2", {31'd0, add_start | in_ready}, 32'd0);
        chk("full_head",  32'(fifo_out), 32'd3);
        result_done = 1'b1;
        chk("full_pop_cycle", 32'(add_start), 32'd0);
        step();
        result_done = 1'b0;
        chk("full_start", 32'(add_start), 32'd1);
        step();
        chk("full_add_a", add_a, 32'hAAAA0000);
        drain_tags[0] = 3'b011; drain_tags[1] = 3'b011;
        drain_tags[2] = 3'b011; drain_tags[3] = 3'b001;
        for (int k = 0; k < 4; k++) begin
            chk($sformatf("drain%0d_head", k), 32'(fifo_out), 32'(drain_tags[k]));
            result_done = 1'b1;
            step();
            result_done = 1'b0;
        end
        chk("drain_empty",    32'(fifo_empty), 32'd1);
        chk("drain_fifo_out", 32'(fifo_out), 32'd0);
        chk("drain_no_uf",    32'(underflow_err), 32'd0);
        add_done = 1'b1; mul_done = 1'b1;
        step();
        add_done = 1'b0; mul_done = 1'b0;

        // ---- reset while a request waits in ISSUE on a busy unit ----
        do_req(3'b011, 32'h12345678, 32'h9ABCDEF0);
        chk("r_first_start", 32'(mul_start), 32'd1);
        step();
        do_req(3'b011, 32'h0BADF00D, 32'h0BADF00D);
        chk("r_held", {31'd0, mul_start | in_ready}, 32'd0);
        #2;
        rst = 1'b1;
        #1;
        chk("r_async_ready", 32'(in_ready), 32'd1);
        chk("r_async_empty", 32'(fifo_empty), 32'd1);
        step();
        rst = 1'b0;
        step();
        chk("r_ready",    32'(in_ready), 32'd1);
        chk("r_empty",    32'(fifo_empty), 32'd1);
        chk("r_fifo_out", 32'(fifo_out), 32'd0);
        chk("r_mul_a",    mul_a, 32'd0);
        seen = 1'b0;
        for (int k = 0; k < 6; k++) begin
            seen = seen | mul_start | add_start | sine_start;
            step();
        end
        chk("r_no_start", 32'(seen), 32'd0);
        chk("r_still_empty", 32'(fifo_empty), 32'd1);
        do_req(3'b011, 32'h40000000, 32'h40400000);
        chk("r_busy_cleared", 32'(mul_start), 32'd1);
        step();
        chk("r_new_mul_a", mul_a, 32'h40000000);
        chk("r_new_tag",   32'(fifo_out), 32'd3);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
